// File: rtl/board_renderer.sv
// ============================================================================
// Module   : board_renderer
// Brief    : Two-stage pixel pipeline drawing a falling-block playfield, its
//            border, the falling piece and a line-clear flash animation.
//            Optional preview panel enabled by defining PREVIEW_PANEL_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module board_renderer #(
  parameter int COLS          = 10,
  parameter int ROWS          = 20,
  parameter int CELL_LOG2     = 4,
  parameter int ORIGIN_X      = 240,
  parameter int ORIGIN_Y      = 60,
  parameter int FLASH_PERIOD  = 8,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic            pixel_clk,
  input  logic            reset_n,
  input  logic [9:0]      DrawX,
  input  logic [9:0]      DrawY,
  input  logic            frame_start,
  input  logic [4:0]      piece_x [4],
  input  logic [4:0]      piece_y [4],
  input  logic            piece_valid,
  input  logic [2:0]      piece_color,
  output logic [4:0]      board_rd_row,
  output logic [4:0]      board_rd_col,
  input  logic [2:0]      board_rd_data,
  input  logic [ROWS-1:0] clear_rows,
  input  logic            flash_start,
  output logic            flash_busy,
  output logic            flash_done,
  input  logic [2:0]      next_shape,
  input  logic            spawn_signal,
  output logic [3:0]      red,
  output logic [3:0]      green,
  output logic [3:0]      blue
);

  localparam int CELL = 1 << CELL_LOG2;
  localparam int FCW  = (FLASH_PERIOD  > 1) ? $clog2(FLASH_PERIOD)  : 1;
  localparam int TCW  = (FLASH_TOGGLES > 1) ? $clog2(FLASH_TOGGLES) : 1;

  localparam logic [10:0] FX0       = 11'(ORIGIN_X);
  localparam logic [10:0] FX1       = 11'(ORIGIN_X + COLS * CELL);
  localparam logic [10:0] FY0       = 11'(ORIGIN_Y);
  localparam logic [10:0] FY1       = 11'(ORIGIN_Y + ROWS * CELL);
  localparam logic [10:0] BX0       = 11'(ORIGIN_X - 2);
  localparam logic [10:0] BX1       = 11'(ORIGIN_X + COLS * CELL + 2);
  localparam logic [10:0] BY0       = 11'(ORIGIN_Y - 2);
  localparam logic [10:0] BY1       = 11'(ORIGIN_Y + ROWS * CELL + 2);
  localparam logic [10:0] CELL_MASK = 11'(CELL - 1);
  localparam logic [10:0] ROW_TOP   = 11'(ROWS - 1);
  localparam logic [4:0]  COLS_W    = 5'(COLS);
  localparam logic [4:0]  ROWS_W    = 5'(ROWS);

  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FLASH_PERIOD - 1);
  localparam logic [FCW-1:0] FRAME_INC  = FCW'(1);
  localparam logic [TCW-1:0] TOG_LAST   = TCW'(FLASH_TOGGLES - 1);
  localparam logic [TCW-1:0] TOG_INC    = TCW'(1);

  function automatic logic [11:0] palette(input logic [2:0] code);
    case (code)
      3'd1:    palette = 12'h0AA;
      3'd2:    palette = 12'hFF5;
      3'd3:    palette = 12'hA0A;
      3'd4:    palette = 12'h00F;
      3'd5:    palette = 12'h550;
      3'd6:    palette = 12'h5F5;
      3'd7:    palette = 12'hA00;
      default: palette = 12'h000;
    endcase
  endfunction

  // ---------------------------------------------------------------- flash FSM
  typedef enum logic [0:0] {IDLE = 1'b0, FLASH = 1'b1} flash_state_t;

  flash_state_t      state, state_n;
  logic              phase, phase_n;
  logic [FCW-1:0]    frame_cnt, frame_cnt_n;
  logic [TCW-1:0]    toggle_cnt, toggle_cnt_n;
  logic [ROWS-1:0]   row_mask, row_mask_n;
  logic              done_n;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      phase      <= 1'b0;
      frame_cnt  <= '0;
      toggle_cnt <= '0;
      row_mask   <= '0;
      flash_done <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      frame_cnt  <= frame_cnt_n;
      toggle_cnt <= toggle_cnt_n;
      row_mask   <= row_mask_n;
      flash_done <= done_n;
    end
  end

  // A frame_start arriving together with flash_start belongs to IDLE and is dropped.
  always_comb begin
    state_n      = state;
    phase_n      = phase;
    frame_cnt_n  = frame_cnt;
    toggle_cnt_n = toggle_cnt;
    row_mask_n   = row_mask;
    done_n       = 1'b0;
    case (state)
      IDLE: begin
        if (flash_start) begin
          state_n      = FLASH;
          row_mask_n   = clear_rows;
          phase_n      = 1'b1;
          frame_cnt_n  = '0;
          toggle_cnt_n = '0;
        end
      end
      FLASH: begin
        if (frame_start) begin
          if (frame_cnt == FRAME_LAST) begin
            frame_cnt_n = '0;
            phase_n     = ~phase;
            if (toggle_cnt == TOG_LAST) begin
              state_n      = IDLE;
              phase_n      = 1'b0;
              toggle_cnt_n = '0;
              done_n       = 1'b1;
            end else begin
              toggle_cnt_n = toggle_cnt + TOG_INC;
            end
          end else begin
            frame_cnt_n = frame_cnt + FRAME_INC;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign flash_busy = (state == FLASH);

  // ------------------------------------------------------ stage 0: geometry
  logic [10:0] x, y, dx, dy;
  logic [4:0]  col, row;
  logic        in_field, in_border, field_gutter;
  logic        piece_hit, flash_hit;
  logic        in_prev, prev_gutter, any_gutter;
  logic [2:0]  prev_color;

  assign x  = {1'b0, DrawX};
  assign y  = {1'b0, DrawY};
  assign dx = x - FX0;
  assign dy = y - FY0;

  assign in_field  = (x >= FX0) && (x < FX1) && (y >= FY0) && (y < FY1);
  assign in_border = !in_field && (x >= BX0) && (x < BX1) && (y >= BY0) && (y < BY1);

  // Screen Y grows downward while board rows count up from the bottom.
  assign col          = 5'(dx >> CELL_LOG2);
  assign row          = 5'(ROW_TOP - (dy >> CELL_LOG2));
  assign field_gutter = ((dx & CELL_MASK) == 11'd0) || ((dy & CELL_MASK) == 11'd0);

  always_comb begin
    piece_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (piece_valid && in_field && (piece_x[i] < COLS_W) && (piece_y[i] < ROWS_W) &&
          (piece_x[i] == col) && (piece_y[i] == row))
        piece_hit = 1'b1;
    end
  end

  assign flash_hit = in_field && (state == FLASH) && phase && row_mask[row];

`ifdef PREVIEW_PANEL_EN
  localparam logic [10:0] PX0 = 11'(ORIGIN_X + (COLS + 2) * CELL);
  localparam logic [10:0] PX1 = 11'(ORIGIN_X + (COLS + 6) * CELL);
  localparam logic [10:0] PY1 = 11'(ORIGIN_Y + 4 * CELL);

  logic [10:0] pdx;
  assign pdx         = x - PX0;
  assign in_prev     = (x >= PX0) && (x < PX1) && (y >= FY0) && (y < PY1);
  assign prev_gutter = ((pdx & CELL_MASK) == 11'd0) || ((dy & CELL_MASK) == 11'd0);
  assign prev_color  = spawn_signal ? next_shape : 3'd0;
`else
  logic unused_preview;
  assign unused_preview = ^{next_shape, spawn_signal};
  assign in_prev        = 1'b0;
  assign prev_gutter    = 1'b0;
  assign prev_color     = 3'd0;
`endif

  assign any_gutter = in_field ? field_gutter : prev_gutter;

  // ------------------------------------------------ stage 1: classification
  logic       s1_field, s1_border, s1_gutter, s1_piece, s1_flash, s1_prev;
  logic [2:0] s1_pcolor, s1_prev_color;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      board_rd_row  <= '0;
      board_rd_col  <= '0;
      s1_field      <= 1'b0;
      s1_border     <= 1'b0;
      s1_gutter     <= 1'b0;
      s1_piece      <= 1'b0;
      s1_flash      <= 1'b0;
      s1_prev       <= 1'b0;
      s1_pcolor     <= '0;
      s1_prev_color <= '0;
    end else begin
      board_rd_row  <= in_field ? row : 5'd0;
      board_rd_col  <= in_field ? col : 5'd0;
      s1_field      <= in_field;
      s1_border     <= in_border;
      s1_gutter     <= any_gutter;
      s1_piece      <= piece_hit;
      s1_flash      <= flash_hit;
      s1_prev       <= in_prev;
      s1_pcolor     <= piece_color;
      s1_prev_color <= prev_color;
    end
  end

  // --------------------------------------------------- stage 2: colour out
  logic [11:0] pix;

  always_comb begin
    pix = 12'h000;
    if (s1_border) begin
      pix = 12'hFFF;
    end else if (s1_field) begin
      if (s1_gutter)      pix = 12'h000;
      else if (s1_flash)  pix = 12'hFFF;
      else if (s1_piece)  pix = palette(s1_pcolor);
      else                pix = palette(board_rd_data);
    end else if (s1_prev && !s1_gutter) begin
      pix = palette(s1_prev_color);
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= pix[11:8];
      green <= pix[7:4];
      blue  <= pix[3:0];
    end
  end

endmodule

`default_nettype wire
